// File: rtl/sqrt_square_rebuild_if.sv
// Handshake bundle for sqrt_square_rebuild: operand request channel and result channel.
// master is the producer/consumer side; slave is the rebuild engine.
interface sqrt_square_rebuild_if #(
  parameter int unsigned q_port_width = 8,
  parameter int unsigned r_port_width = 9,
  parameter int unsigned width        = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [q_port_width-1:0] q;
  logic [r_port_width-1:0] remainder;
  logic                    out_valid;
  logic                    out_ready;
  logic [width-1:0]        radical;
  logic                    overflow;
  logic                    noncanon;

  modport master (
    output in_valid,
    output q,
    output remainder,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  radical,
    input  overflow,
    input  noncanon
  );

  modport slave (
    input  in_valid,
    input  q,
    input  remainder,
    input  out_ready,
    output in_ready,
    output out_valid,
    output radical,
    output overflow,
    output noncanon
  );
endinterface

// File: rtl/sqrt_square_rebuild.sv
// Rebuilds radical = q*q + remainder with a shift-add loop, one bit of q per enabled cycle.
// One operation in flight; valid/ready on both sides, clock enable freezes everything.
module sqrt_square_rebuild #(
  parameter int unsigned q_port_width = 8,
  parameter int unsigned r_port_width = 9,
  parameter int unsigned width        = 16
) (
  input logic                 clk,
  input logic                 aclr,
  input logic                 ena,
  sqrt_square_rebuild_if.slave bus
);

  localparam int unsigned ProdW = 2 * q_port_width;
  localparam int unsigned AccW  = ((ProdW > r_port_width) ? ProdW : r_port_width) + 1;
  localparam int unsigned ExtW  = (AccW > width) ? AccW : width;
  localparam int unsigned CntW  = (q_port_width > 1) ? $clog2(q_port_width) : 1;
  localparam int unsigned CmpW  = ((q_port_width + 1) > r_port_width) ? (q_port_width + 1)
                                                                      : r_port_width;
  localparam logic [CntW-1:0] LastCnt = CntW'(q_port_width - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q;
  logic [q_port_width-1:0] q_l;
  logic [r_port_width-1:0] r_l;
  logic [AccW-1:0]         acc_q;
  logic [AccW-1:0]         acc_next;
  logic [CntW-1:0]         cnt_q;
  logic                    out_valid_q;
  logic [width-1:0]        radical_q;
  logic                    overflow_q;
  logic                    noncanon_q;

  logic [ExtW-1:0]         acc_ext;
  logic                    ovf_next;
  logic                    nc_next;

  // q*q = sum over set bits i of (q << i); remainder is preloaded into acc.
  always_comb begin
    acc_next = acc_q;
    if (q_l[cnt_q]) begin
      acc_next = acc_q + (AccW'(q_l) << cnt_q);
    end
  end

  assign acc_ext = ExtW'(acc_next);

  generate
    if (AccW > width) begin : g_ovf
      assign ovf_next = |acc_ext[ExtW-1:width];
    end else begin : g_no_ovf
      assign ovf_next = 1'b0;
    end
  endgenerate

  // A genuine square-root output always satisfies remainder <= 2*q.
  assign nc_next = CmpW'(r_l) > (CmpW'(q_l) << 1);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= StIdle;
      q_l         <= '0;
      r_l         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      radical_q   <= '0;
      overflow_q  <= 1'b0;
      noncanon_q  <= 1'b0;
    end else if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            q_l     <= bus.q;
            r_l     <= bus.remainder;
            acc_q   <= AccW'(bus.remainder);
            cnt_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          if (cnt_q == LastCnt) begin
            radical_q   <= acc_ext[width-1:0];
            overflow_q  <= ovf_next;
            noncanon_q  <= nc_next;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle) & ena;
  assign bus.out_valid = out_valid_q;
  assign bus.radical   = radical_q;
  assign bus.overflow  = overflow_q;
  assign bus.noncanon  = noncanon_q;

endmodule

// File: tb/tb_sqrt_square_rebuild.sv
// Directed and table-driven bench for sqrt_square_rebuild at default widths (8/9/16).
module tb_sqrt_square_rebuild;

  logic clk = 1'b0;
  logic aclr;
  logic ena;

  always #5 clk = ~clk;

  sqrt_square_rebuild_if #(.q_port_width(8), .r_port_width(9), .width(16)) bus ();

  sqrt_square_rebuild #(.q_port_width(8), .r_port_width(9), .width(16)) dut (
    .clk  (clk),
    .aclr (aclr),
    .ena  (ena),
    .bus  (bus)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_pass  = 0;
  int n_total = 0;
  int acc_edge;

  typedef struct {
    logic [7:0]  q;
    logic [8:0]  r;
    logic [15:0] exp_rad;
    logic        exp_ovf;
    logic        exp_nc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [7:0] qv, input logic [8:0] rv);
    int n = 0;
    bus.q         = qv;
    bus.remainder = rv;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    acc_edge     = edge_cnt;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) check("result_timeout", 32'(bus.out_valid), 32'd1);
    lat = edge_cnt - acc_edge;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          full;
    int          seen;
    logic [7:0]  qv;
    logic [8:0]  rv;

    vecs[0] = '{q: 8'd12,   r: 9'd5,     exp_rad: 16'd149,   exp_ovf: 1'b0, exp_nc: 1'b0};
    vecs[1] = '{q: 8'hFF,   r: 9'h1FE,   exp_rad: 16'hFFFF,  exp_ovf: 1'b0, exp_nc: 1'b0};
    vecs[2] = '{q: 8'hFF,   r: 9'h1FF,   exp_rad: 16'h0000,  exp_ovf: 1'b1, exp_nc: 1'b1};
    vecs[3] = '{q: 8'd0,    r: 9'd0,     exp_rad: 16'd0,     exp_ovf: 1'b0, exp_nc: 1'b0};
    vecs[4] = '{q: 8'd1,    r: 9'd3,     exp_rad: 16'd4,     exp_ovf: 1'b0, exp_nc: 1'b1};
    vecs[5] = '{q: 8'd16,   r: 9'd33,    exp_rad: 16'd289,   exp_ovf: 1'b0, exp_nc: 1'b1};
    vecs[6] = '{q: 8'h80,   r: 9'h100,   exp_rad: 16'd16640, exp_ovf: 1'b0, exp_nc: 1'b0};
    vecs[7] = '{q: 8'd200,  r: 9'd0,     exp_rad: 16'd40000, exp_ovf: 1'b0, exp_nc: 1'b0};
    vecs[8] = '{q: 8'd0,    r: 9'd511,   exp_rad: 16'd511,   exp_ovf: 1'b0, exp_nc: 1'b1};

    aclr          = 1'b1;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.q         = '0;
    bus.remainder = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_radical",   32'(bus.radical),   32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_noncanon",  32'(bus.noncanon),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    ena = 1'b0;
    #1;
    check("rst_in_ready_ena0", 32'(bus.in_ready), 32'd0);
    ena = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);

    // Table: latency, result, one-cycle pulse, in_ready returning.
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].q, vecs[i].r);
      wait_out(lat);
      check("tbl_latency",  32'(lat),          32'd8);
      check("tbl_radical",  32'(bus.radical),  32'(vecs[i].exp_rad));
      check("tbl_overflow", 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      check("tbl_noncanon", 32'(bus.noncanon), 32'(vecs[i].exp_nc));
      @(negedge clk);
      check("tbl_pulse_end", 32'(bus.out_valid), 32'd0);
      check("tbl_in_ready",  32'(bus.in_ready),  32'd1);
    end

    // Backpressure with a pending input that must not be taken early.
    bus.out_ready = 1'b0;
    start_op(8'd3, 9'd2);
    wait_out(lat);
    check("bp_radical", 32'(bus.radical), 32'd11);
    bus.q         = 8'd7;
    bus.remainder = 9'd1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid",   32'(bus.out_valid), 32'd1);
      check("bp_hold_radical", 32'(bus.radical),   32'd11);
      check("bp_hold_inready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_valid",   32'(bus.out_valid), 32'd0);
    check("bp_handshake_inready", 32'(bus.in_ready),  32'd1);
    @(negedge clk);
    check("bp_accepted", 32'(bus.in_ready), 32'd0);
    acc_edge     = edge_cnt;
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("bp2_latency", 32'(lat),         32'd8);
    check("bp2_radical", 32'(bus.radical), 32'd50);
    @(negedge clk);

    // Clock-enable stall for three cycles in mid-CALC.
    start_op(8'd12, 9'd5);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid",   32'(bus.out_valid), 32'd0);
      check("stall_radical", 32'(bus.radical),   32'd50);
      check("stall_inready", 32'(bus.in_ready),  32'd0);
    end
    ena = 1'b1;
    wait_out(lat);
    check("stall_latency", 32'(lat),         32'd11);
    check("stall_radical_final", 32'(bus.radical), 32'd149);
    @(negedge clk);

    // Asynchronous reset at CALC cycle 4.
    start_op(8'd100, 9'd7);
    repeat (4) @(negedge clk);
    aclr = 1'b1;
    #1;
    check("aclr_valid",   32'(bus.out_valid), 32'd0);
    check("aclr_radical", 32'(bus.radical),   32'd0);
    @(negedge clk);
    aclr = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("aclr_no_pulse", 32'(seen), 32'd0);
    start_op(8'd200, 9'd0);
    wait_out(lat);
    check("post_aclr_latency", 32'(lat),         32'd8);
    check("post_aclr_radical", 32'(bus.radical), 32'd40000);
    @(negedge clk);

    // Random canonical sweep against a reference model.
    for (int i = 0; i < 1000; i++) begin
      qv   = 8'($urandom_range(0, 255));
      rv   = 9'($urandom_range(0, 2 * int'(qv)));
      full = int'(qv) * int'(qv) + int'(rv);
      start_op(qv, rv);
      wait_out(lat);
      check("rnd_radical",  32'(bus.radical),  32'(full[15:0]));
      check("rnd_overflow", 32'(bus.overflow), 32'(full > 65535));
      check("rnd_noncanon", 32'(bus.noncanon), 32'd0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sqrt_square_rebuild.md
# sqrt_square_rebuild

Sequential inverse of the integer square-root function: accepts a root `q` and remainder `remainder` and rebuilds `radical = q*q + remainder` with an iterative shift-add engine, one bit of `q` per enabled cycle. Used in the emulator sample to regenerate radicals from square-root results and as a self-check partner for the square-root block. Valid/ready handshakes on both sides; one operation in flight.

## Interface
- `q_port_width`, default 8: width of `q` and number of iteration cycles.
- `r_port_width`, default 9: width of `remainder`.
- `width`, default 16: width of the `radical` output.
- `clk`  in  1: clock; all state changes on the rising edge.
- `aclr`  in  1: reset; asynchronous, active-high.
- `ena`  in  1: clock enable. When low, all registers hold and no handshake completes.
- `in_valid`  in  1: `q`/`remainder` present.
- `in_ready`  out  1: combinational, equals `(state==IDLE) & ena`.
- `q`  in  q_port_width: unsigned root.
- `remainder`  in  r_port_width: unsigned remainder.
- `out_valid`  out  1: result present (registered).
- `out_ready`  in  1: consumer accepts the result.
- `radical`  out  width: `(q*q + remainder)` truncated to `width` bits (registered).
- `overflow`  out  1: the full result exceeds `width` bits.
- `noncanon`  out  1: `remainder > 2*q`, so the input cannot be a square-root output.

## Operation
- Internal accumulator `acc` is `max(2*q_port_width, r_port_width) + 1` bits wide. The full sum never wraps.
- Latched operands: `q_l` and `r_l`. Bit counter `cnt` is `ceil(log2(q_port_width))` bits, minimum 1.
- The FSM has three states, IDLE, CALC and DONE. Every transition below requires `ena=1`.
  - IDLE: when `in_valid & in_ready`, latch `q_l=q` and `r_l=remainder`, set `acc` to `remainder` zero-extended, set `cnt=0`, and go to CALC.
  - CALC: if `q_l[cnt]` is set, `acc += q_l << cnt`. When `cnt == q_port_width-1`, go to DONE; otherwise `cnt++`.
  - DONE entry (the same edge that leaves CALC):
    - `radical <= acc_next[width-1:0]`
    - `overflow <= |acc_next[top:width]`, or 0 if `acc` is not wider than `width`
    - `noncanon <= (r_l > 2*q_l)`, compared at full width
    - `out_valid <= 1`
  - DONE: when `out_valid & out_ready & ena`, clear `out_valid` and go to IDLE. `radical`, `overflow` and `noncanon` keep their values until the next DONE entry.
- `in_ready` is 0 in CALC and DONE. An `in_valid` during those states is ignored and stays pending upstream.
- `ena=0` in any state freezes the state, `cnt`, `acc` and all outputs. `in_ready` reads 0 during that time.
- `aclr` at any time, including mid-CALC:
  - state=IDLE, `cnt=0`, `acc=0`, `q_l=0`, `r_l=0`
  - `out_valid=0`, `radical=0`, `overflow=0`, `noncanon=0`
  - any in-flight operation is discarded

## Timing
- Reset values: `out_valid=0`, `radical=0`, `overflow=0`, `noncanon=0`, `in_ready=ena`.
- Latency with `ena` held high: accept on edge k, then `out_valid=1` after edge k+`q_port_width`.
- Each `ena=0` cycle during CALC adds exactly one cycle of latency.
- The output handshake completes on an edge where `out_valid & out_ready & ena`. `in_ready` goes high right after that edge.
- The earliest next accept is the edge following that, so minimum issue interval is `q_port_width+2` cycles.
- When `out_ready` is tied high, `out_valid` is a one-cycle pulse.
- `q_port_width=1`: CALC lasts one cycle and the result is `q + remainder`.

## Test plan
Defaults: `q_port_width=8`, `r_port_width=9`, `width=16`.
- **Latency.** Reset, then send `q=12`, `remainder=5` with `out_ready=1`.
  - Expect `radical=149`, `overflow=0`, `noncanon=0`.
  - `out_valid` rises exactly 8 edges after the accept edge and lasts one cycle.
  - `in_ready` returns after it.
- **Maximum value, full width.** Send `q=0xFF`, `remainder=0x1FE`.
  - Expect `radical=0xFFFF`, `overflow=0`, `noncanon=0`.
- **Overflow.** Send `q=0xFF`, `remainder=0x1FF`; the full sum is 65536.
  - Expect `radical=0x0000`, `overflow=1`, `noncanon=1`.
- **Backpressure and ignored input.** Send `q=3`, `remainder=2` and hold `out_ready=0` for 5 cycles after `out_valid` rises.
  - `out_valid` stays 1, `radical` holds 11, and `in_ready` stays 0.
  - A new `in_valid` raised during the wait is not accepted.
  - After the `out_ready` handshake, that input is accepted on the second following edge.
- **Enable stall.** Drop `ena` for 3 cycles in mid-CALC.
  - Expect latency of 11 edges and the correct result.
  - Outputs stay frozen while `ena=0`.
- **Reset mid-operation.** Assert `aclr` at CALC cycle 4.
  - `out_valid` and `radical` go to 0 immediately, with no output pulse afterwards.
  - A subsequent operation with `q=200`, `remainder=0` gives `radical=40000`.
  - Then a random sweep of 1000 pairs, with `remainder` drawn from 0..2q, must match a reference model with `noncanon=0`.
